// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and entry type for the fetch queue
package fetch_pkg;
  localparam int FQ_DEPTH = 4;
  localparam int FQ_W = 32;
  localparam int FQ_PTR_W = $clog2(FQ_DEPTH);
  localparam int FQ_CNT_W = $clog2(FQ_DEPTH + 1);
  typedef struct packed {
    logic [FQ_W-1:0] pc;
    logic [FQ_W-1:0] instruction;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: entry storage with sync write, async read, sync clear
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);
  fq_entry_t mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode decoupling buffer with flush on taken branch
// Define FETCH_QUEUE_BYPASS_EN for zero-latency handover when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int W     = FQ_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 if_pc,
  input  logic [W-1:0]                 if_instruction,
  input  logic                         branch_taken,
  output logic                         stall,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [W-1:0]                 id_pc,
  output logic [W-1:0]                 id_instruction,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic byp, push, pop, we, deq;
  fq_entry_t rdata;
  assign stall = count_q == CW'(DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = count_q == '0 && !branch_taken && !stall;
`else
  assign byp = 1'b0;
`endif
  assign id_valid       = (count_q != '0 || byp) && !branch_taken;
  assign id_pc          = byp ? if_pc : rdata.pc;
  assign id_instruction = byp ? if_instruction : rdata.instruction;
  assign pop  = id_valid && id_ready;
  assign push = !stall && !branch_taken;
  // a bypassed pair taken by decode is never stored
  assign we  = push && !(byp && id_ready);
  assign deq = pop && !byp;
  assign count = count_q;
  always_comb begin
    rd_ptr_d = branch_taken ? '0 : rd_ptr_q + AW'(deq);
    wr_ptr_d = branch_taken ? '0 : wr_ptr_q + AW'(we);
    count_d  = branch_taken ? '0 : count_q + CW'(we) - CW'(deq);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata ('{pc: if_pc, instruction: if_instruction}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus random checking of fetch_queue against a queue model
module tb_fetch_queue;
  import fetch_pkg::*;
  localparam int D = FQ_DEPTH;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, branch_taken = 1'b0, id_ready = 1'b0;
  logic [31:0] if_pc = '0, if_instruction = '0;
  logic stall, id_valid;
  logic [31:0] id_pc, id_instruction;
  logic [FQ_CNT_W-1:0] count;
  always #5 clk = ~clk;
  fetch_queue dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
    .branch_taken(branch_taken), .stall(stall), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_instruction(id_instruction), .count(count)
  );
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t q[$];
  int tests = 0, fails = 0;
  logic [31:0] fpc = '0, fins = '0, tgt = '0;
  bit m_r, m_bt, m_byp, m_pop, m_push, m_stall;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // drive one cycle's inputs and compare outputs with the model
  task automatic setc(bit r, bit bt, bit rdy, logic [31:0] t);
    bit ev;
    rst = r; branch_taken = bt; id_ready = rdy; if_pc = fpc; if_instruction = fins; tgt = t;
    #2;
    m_r = r; m_bt = bt;
    m_stall = q.size() == D;
    m_byp = BYP && q.size() == 0 && !bt;
    ev = (q.size() != 0 || m_byp) && !bt;
    if (!r) begin
      chk("count", 32'(count), q.size());
      chk("stall", 32'(stall), 32'(m_stall));
      chk("id_valid", 32'(id_valid), 32'(ev));
      if (ev) begin
        chk("id_pc", id_pc, m_byp ? fpc : q[0].pc);
        chk("id_instruction", id_instruction, m_byp ? fins : q[0].ins);
      end
    end
    m_pop = ev && rdy;
    m_push = !m_stall && !bt;
  endtask
  task automatic adv();
    @(posedge clk);
    if (m_r || m_bt) q.delete();
    else begin
      if (m_pop && !m_byp) void'(q.pop_front());
      if (m_push && !(m_byp && m_pop)) q.push_back('{pc: fpc, ins: fins});
    end
    if (m_bt) begin fpc = tgt; fins = $urandom; end
    else if (!m_stall) begin fpc = fpc + 4; fins = $urandom; end
    @(negedge clk);
  endtask
  task automatic cyc(bit r, bit bt, bit rdy);
    setc(r, bt, rdy, {$urandom_range(0, 32'h3fff_ffff), 2'b00});
    adv();
  endtask
  initial begin
    @(negedge clk);
    fins = $urandom;
    cyc(1, 0, 1);
    setc(1, 1, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_ins", id_instruction, 0);
    adv();
    fpc = 0; q.delete();
    repeat (4) cyc(0, 0, 0);
    setc(0, 0, 0, 0);
    chk("fill_count", 32'(count), 4);
    chk("fill_stall", 32'(stall), 1);
    chk("fill_pc", id_pc, 0);
    adv();
    setc(0, 0, 1, 0);
    chk("held_count", 32'(count), 4);
    adv();
    setc(0, 0, 0, 0);
    chk("fullpop_count", 32'(count), 3);
    chk("fullpop_stall", 32'(stall), 0);
    adv();
    setc(0, 0, 0, 0);
    chk("refill_count", 32'(count), 4);
    chk("refill_pc", id_pc, 4);
    adv();
    cyc(0, 0, 1);
    setc(0, 1, 1, 32'h80);
    chk("flush_valid", 32'(id_valid), 0);
    chk("flush_count", 32'(count), 3);
    adv();
    setc(0, 0, 0, 0);
    chk("postflush_count", 32'(count), 0);
    adv();
    setc(0, 0, 0, 0);
    chk("target_valid", 32'(id_valid), 1);
    chk("target_pc", id_pc, 32'h80);
    chk("target_count", 32'(count), 1);
    adv();
    for (int i = 0; i < 3; i++) begin
      setc(0, 0, 1, 0);
      chk("drain_count", 32'(count), 2);
      chk("drain_pc", id_pc, 32'h80 + 4 * i);
      adv();
    end
    setc(0, 1, 0, 32'h40);
    adv();
    setc(0, 0, 1, 0);
    if (BYP) begin
      chk("byp_valid", 32'(id_valid), 1);
      chk("byp_pc", id_pc, 32'h40);
    end else chk("nobyp_valid", 32'(id_valid), 0);
    adv();
    setc(0, 0, 1, 0);
    if (BYP) chk("byp_count", 32'(count), 0);
    else begin
      chk("nobyp_pc", id_pc, 32'h40);
      chk("nobyp_count", 32'(count), 1);
    end
    adv();
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer on the receiving side of the instruction-fetch interface. Captures the (PC, instruction) pair presented by the fetch stage each non-stalled cycle and drives the fetch `stall` input whenever it is full. Presents entries in order to the decode stage through a valid/ready handshake. Flushes all buffered instructions when a branch is taken.

## Interface

**Parameters**
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `W`, 32: width of both the PC and the instruction.

**Ports**
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_pc`  in  W  PC currently presented by the fetch stage.
- `if_instruction`  in  W  instruction at `if_pc`.
- `branch_taken`  in  1  branch resolved taken; the fetch stage loads the target on the same edge.
- `stall`  out  1  to the fetch stage; holds its PC.
- `id_valid`  out  1  head entry available to decode.
- `id_ready`  in  1  decode accepts the head entry this cycle.
- `id_pc`  out  W  PC of the head entry.
- `id_instruction`  out  W  instruction of the head entry.
- `count`  out  clog2(DEPTH+1)  current occupancy.

## Operation

- **Storage:** circular array of DEPTH entries {pc, instruction}, with `rd_ptr`, `wr_ptr` (log2(DEPTH) bits, wrap modulo DEPTH) and `count`.
- **Stall:** `stall = (count == DEPTH)`. Driven from registered state only, with no combinational path from inputs.
- **Push:** `push = ~stall & ~branch_taken`. Whenever the fetch stage is not stalled it advances its PC, so the presented pair is consumed by this block on that edge.
- **Pop:** `pop = id_valid & id_ready`.
- **Visibility:** `id_valid = (count != 0) & ~branch_taken`.
  - `id_pc`/`id_instruction` show the entry at `rd_ptr`.
  - When `id_valid = 0`, these outputs hold their last values; this is don't-care for checking.
- **Flush:** on `branch_taken`, all entries are younger than the resolving branch.
  - Next edge: `count`, `rd_ptr`, `wr_ptr` go to 0.
  - No push and no pop occur that cycle.
  - `branch_taken` dominates `id_ready`.
- **Simultaneous push and pop:** `count` unchanged; both pointers advance.
- **Full:**
  - No push is possible while full.
  - A pop while full lowers `count` to DEPTH-1, and `stall` deasserts on the following cycle.
- **Empty:** pop is impossible (`id_valid = 0`).
- **Reset:** clears mid-operation at the next edge.
  - `count = 0`, pointers 0, `stall = 0`, `id_valid = 0`.
  - `id_pc = 0`, `id_instruction = 0`; storage is cleared to 0.

## Timing

- Latency from push to `id_valid` is one cycle: an entry written at edge N is visible after edge N (bypass described under Configuration).
- Throughput is one instruction per cycle in steady state when `id_ready` is held high.
- A flush asserted in cycle N means the branch target, fetched in N+1, is pushed at the end of N+1 and visible in N+2.
- `stall` reacts one cycle after the occupancy change that causes it.

## Configuration

- **`FETCH_QUEUE_BYPASS_EN` defined:**
  - When `count == 0`, `branch_taken = 0` and `stall = 0`: `id_valid = 1` combinationally, with `id_pc`/`id_instruction` taken straight from `if_pc`/`if_instruction`.
  - If `id_ready` is also high, the pair is handed over directly and not written; `count` stays 0.
  - If `id_ready` is low, the pair is pushed normally.
  - Result: zero-cycle latency when empty.
- **Not defined:** no combinational path from the `if_*` inputs to the `id_*` outputs; latency is always one cycle.

## Structure

- **Package `fetch_pkg`:**
  - `FQ_DEPTH`, `FQ_W` constants.
  - `fq_entry_t` typedef {pc, instruction}.
  - Pointer/count width constants derived via `$clog2`.
- **Sub-module `fetch_queue_mem`:**
  - DEPTH x `fq_entry_t` array.
  - One synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`).
  - Synchronous clear on `rst`.
- **Top level** holds the pointers, count, handshake, flush and bypass logic.

## Test plan

- **Reset:** hold `rst` 2 cycles during traffic → `count=0`, `stall=0`, `id_valid=0`, `id_pc=0`.
- **Fill:** `id_ready=0`, fetch presents PCs 0,4,8,12 → after 4 edges `count=4`, `stall=1`, `id_pc=0`; PC 16 is held by fetch and not captured.
- **Drain with concurrent push:** `id_ready=1` from `count=2` → pops PCs in order 0,4,8,… one per cycle, `count` stays 2.
- **Full pop:** `count=4`, `id_ready=1` one cycle → `count=3`, `stall` low next cycle, PC 16 pushed the cycle after.
- **Flush:** `count=3`, `branch_taken=1` with `id_ready=1` → `id_valid=0` that cycle, no pop, `count=0` next cycle; target 0x80 visible two cycles after the flush.
- **Bypass:** empty, `id_ready=1`, `if_pc=0x40`:
  - with `FETCH_QUEUE_BYPASS_EN` → `id_valid=1`, `id_pc=0x40` in the same cycle, `count` stays 0;
  - without → `id_valid=1`, `id_pc=0x40` one cycle later.
